// File: rtl/io_output_bank_if.sv
// rtl/io_output_bank_if.sv - CPU store/load bus into the output register bank
interface io_output_bank_if;
  logic [31:0] addr;
  logic [31:0] datain;
  logic        write_io_enable;
  logic [31:0] rdata;

  modport master (output addr, output datain, output write_io_enable, input rdata);
  modport slave  (input addr, input datain, input write_io_enable, output rdata);
endinterface

// File: rtl/io_output_bank.sv
// rtl/io_output_bank.sv - output port bank with set/clear/toggle aliases and prescaled blink
module io_output_bank #(
  parameter int               NUM_PORTS = 4,
  parameter int               WIDTH     = 32,
  parameter logic [5:0]       BASE_IDX  = 6'd32,
  parameter int               DIV_W     = 24,
  parameter logic [DIV_W-1:0] DIV_RST   = 24'd2_500_000
) (
  input  logic                       io_clk,
  input  logic                       clr,
  io_output_bank_if.slave            bus,
  output logic [NUM_PORTS*WIDTH-1:0] out_ports
);

  localparam int BASE     = int'(BASE_IDX);
  localparam int MASK_IDX = BASE + 4 * NUM_PORTS;
  localparam int DIV_IDX  = BASE + 5 * NUM_PORTS;

  logic [WIDTH-1:0]           data_q [NUM_PORTS];
  logic [WIDTH-1:0]           data_d [NUM_PORTS];
  logic [WIDTH-1:0]           mask_q [NUM_PORTS];
  logic [WIDTH-1:0]           mask_d [NUM_PORTS];
  logic [DIV_W-1:0]           div_q, div_d;
  logic [DIV_W-1:0]           cnt_q, cnt_d;
  logic                       phase_q, phase_d;
  logic [NUM_PORTS*WIDTH-1:0] out_d;
  logic [WIDTH-1:0]           wd;
  logic                       div_wr;
  int                         idx;
  logic                       unused_bits;

  assign unused_bits = ^{bus.addr[31:8], bus.addr[1:0], bus.datain};

  always_comb begin
    idx    = int'(bus.addr[7:2]);
    wd     = bus.datain[WIDTH-1:0];
    div_wr = bus.write_io_enable && (idx == DIV_IDX);
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      data_d[p] = data_q[p];
      mask_d[p] = mask_q[p];
      if (bus.write_io_enable) begin
        if (idx == BASE + 4 * p)     data_d[p] = wd;
        if (idx == BASE + 4 * p + 1) data_d[p] = data_q[p] | wd;
        if (idx == BASE + 4 * p + 2) data_d[p] = data_q[p] & ~wd;
        if (idx == BASE + 4 * p + 3) data_d[p] = data_q[p] ^ wd;
        if (idx == MASK_IDX + p)     mask_d[p] = wd;
      end
    end
    div_d = div_wr ? bus.datain[DIV_W-1:0] : div_q;
  end

  // A divisor write restarts the blink from a known phase, overriding the terminal count.
  always_comb begin
    cnt_d   = cnt_q + DIV_W'(1);
    phase_d = phase_q;
    if (div_wr) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == div_q) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  // Output is registered from next-state values so writes show up on the same edge.
  always_comb begin
    out_d = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      out_d[p*WIDTH +: WIDTH] = data_d[p] ^ (mask_d[p] & {WIDTH{phase_d}});
  end

  always_comb begin
    bus.rdata = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (idx >= BASE + 4 * p && idx <= BASE + 4 * p + 3) bus.rdata = 32'(data_q[p]);
      if (idx == MASK_IDX + p)                            bus.rdata = 32'(mask_q[p]);
    end
    if (idx == DIV_IDX) bus.rdata = 32'(div_q);
  end

  always_ff @(posedge io_clk or posedge clr) begin
    if (clr) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        data_q[p] <= '0;
        mask_q[p] <= '0;
      end
      div_q     <= DIV_RST;
      cnt_q     <= '0;
      phase_q   <= 1'b0;
      out_ports <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        data_q[p] <= data_d[p];
        mask_q[p] <= mask_d[p];
      end
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      out_ports <= out_d;
    end
  end

endmodule

// File: doc/io_output_bank.md
Name: io_output_bank

Overview:
- Parametrised memory-mapped output register bank; successor to the single-port output register in the CPU's I/O space.
- Provides NUM_PORTS output ports with atomic set/clear/toggle write aliases, per-bit hardware blink driven by a shared programmable prescaler, and CPU readback of all registers.
- Sits on the store path of the single-cycle CPU (decodes addr[7:2], qualified by write_io_enable) and drives LEDs/7-seg/GPIO.

Parameters:
- NUM_PORTS, 4, number of output ports (1..8).
- WIDTH, 32, bits per port (1..32); uses datain[WIDTH-1:0].
- BASE_IDX, 6'd32, word index (addr[7:2]) of port 0 DATA. Legal only when BASE_IDX + 5*NUM_PORTS + 1 <= 64.
- DIV_W, 24, prescaler width.
- DIV_RST, 24'd2_500_000, reset value of the blink divisor.

Ports:
- io_clk, in, 1: single clock; all state updates on posedge.
- clr, in, 1: asynchronous, active-high reset.
- addr, in, 32: byte address; only addr[7:2] decoded, all other bits ignored.
- datain, in, 32: write data.
- write_io_enable, in, 1: write strobe, sampled at posedge.
- rdata, out, 32: combinational readback of the register selected by addr.
- out_ports, out, NUM_PORTS*WIDTH: port p occupies bits [p*WIDTH +: WIDTH]; registered.

Behaviour:
- Word map, idx = addr[7:2], p = 0..NUM_PORTS-1:
  - BASE_IDX+4p+0: DATA. Write: data[p] <= d.
  - BASE_IDX+4p+1: SET. Write: data[p] <= data[p] | d.
  - BASE_IDX+4p+2: CLR. Write: data[p] <= data[p] & ~d.
  - BASE_IDX+4p+3: TGL. Write: data[p] <= data[p] ^ d.
  - BASE_IDX+4*NUM_PORTS+p: MASK[p], the per-bit blink enable.
  - BASE_IDX+5*NUM_PORTS: DIV.
  - Here d = datain[WIDTH-1:0]. A write to DIV stores datain[DIV_W-1:0].
- Writes with unmapped idx, or with write_io_enable=0, change nothing.
- Prescaler: cnt (DIV_W bits) and phase (1 bit).
  - Every cycle: if cnt == div then cnt <= 0 and phase <= ~phase; else cnt <= cnt+1.
  - div=0 toggles phase every cycle. Half-period = div+1 cycles.
  - A DIV write has priority over the prescaler step: cnt <= 0, phase <= 0 on that edge.
- Output: out_ports[p] <= data_next[p] ^ (mask_next[p] & {WIDTH{phase_next}}).
  - This is a registered output computed from next-state values, so a write at edge N is visible on out_ports immediately after edge N (zero-cycle latency relative to the register update).
- Readback (combinational, zero-extended to 32 bits, unmapped reads return 0):
  - DATA/SET/CLR/TGL aliases of port p all return data[p], the unblinked value.
  - MASK returns mask[p].
  - DIV returns div.
- Reset (clr=1, asynchronous, takes effect at any time including mid-blink):
  - data = 0, mask = 0, div = DIV_RST, cnt = 0, phase = 0, out_ports = 0.
  - On release, the first posedge resumes counting from cnt=0.
- Only one write per cycle, so no register conflicts. A DIV write coinciding with a terminal count is resolved by the DIV-write rule above.
- With mask=0 the output equals data regardless of phase.

Test Plan:
- Reset then release, no writes -> out_ports=0. Read idx BASE_IDX+5*NUM_PORTS -> rdata=DIV_RST. Read idx 0 -> rdata=0.
- Write DATA p1=0x0000_00F0, then SET p1=0x0F, CLR p1=0x30, TGL p1=0x101 -> p1 after each edge = 0xF0, 0xFF, 0xCF, 0x1CE. Other ports stay 0. rdata at DATA p1 = 0x1CE.
- Write DIV=3, MASK p0=0x1, DATA p0=0x2 -> out p0 alternates 0x2 and 0x3 every 4 cycles, starting with 0x2 for 4 cycles after the DIV write.
- While blinking with DIV=3, write DIV=0 at cnt=2 -> cnt and phase clear on that edge, then phase toggles every cycle.
- Write with addr[7:2]=BASE_IDX+5*NUM_PORTS+1 (unmapped), and a mapped address with write_io_enable=0 -> no state change. Upper address bits set (addr=0xFFFF_FF80 | (BASE_IDX<<2)) -> decoded as port 0 DATA.
- Assert clr asynchronously mid-cycle while out p0=0x3 -> out_ports=0 immediately, before the next io_clk edge. After release, blinking restarts only once MASK and DATA are rewritten (they reset to 0).
